// File: rtl/mysopc_onchip_ram_pipelined.sv
// mysopc_onchip_ram_pipelined
// Avalon-MM on-chip RAM slave with 1- or 2-cycle read latency, waitrequest
// flow control, optional zero-fill after reset and out-of-range protection.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   clken               clock enable; 0 freezes every piece of state
//   chipselect, read, write, address, byteenable, writedata
//                       Avalon-MM slave request
//   readdata            read data, meaningful only with readdatavalid
//   readdatavalid       one pulse per accepted read
//   waitrequest         1 = request not accepted this cycle
//   oob_error           sticky flag, set by any accepted access >= DEPTH
module mysopc_onchip_ram_pipelined #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned DEPTH          = 12000,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "MySOPC_onchip_memory2_0.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    oob_error
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   clr_idx;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   in_range;
  logic [IDX_WIDTH-1:0]   word_idx;
  logic                   accept;
  logic                   wr_accept;
  logic                   rd_accept;
  logic                   clr_active;
  logic                   wr_en;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic [BE_WIDTH-1:0]    wr_be;
  logic [DATA_WIDTH-1:0]  wr_data;

  logic                   s1_valid;
  logic [DATA_WIDTH-1:0]  s1_data;
  logic                   out_valid;

  // The power-up image is attached to the array by the configuration flow;
  // an empty name simply means the array starts undefined.
  if (INIT_FILE == "") begin : g_no_image
  end

  // Request decode and the single shared write port (clear or bus write).
  always_comb begin
    in_range   = 32'(address) < DEPTH;
    word_idx   = address[IDX_WIDTH-1:0];
    accept     = chipselect & (read | write) & (state == ST_READY) & clken & ~reset;
    wr_accept  = accept & write;
    rd_accept  = accept & read & ~write;
    clr_active = CLEAR_ON_RESET && (state != ST_READY) && clken && !reset;

    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = byteenable;
    wr_data = writedata;
    if (clr_active) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_be   = '1;
      wr_data = '0;
    end else if (wr_accept && in_range) begin
      wr_en = 1'b1;
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Control FSM, clear counter and sticky error flag.
  // The RESET state already writes word 0, so the whole clear costs exactly
  // DEPTH enabled cycles of waitrequest after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RESET;
      clr_idx   <= '0;
      oob_error <= 1'b0;
    end else if (clken) begin
      case (state)
        ST_RESET: begin
          if (CLEAR_ON_RESET && DEPTH > 1) begin
            state   <= ST_CLEAR;
            clr_idx <= IDX_WIDTH'(1);
          end else begin
            state <= ST_READY;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= ST_READY;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + IDX_WIDTH'(1);
          end
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_RESET;
      endcase
      if (accept && !in_range) begin
        oob_error <= 1'b1;
      end
    end
  end

  // First read stage: synchronous array read; data only moves on a read so
  // readdata holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (clken) begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_data <= in_range ? mem[word_idx] : '0;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    // Extra output register stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (clken) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign out_valid = s2_valid;
    assign readdata  = s2_data;
  end else begin : g_lat1
    assign out_valid = s1_valid;
    assign readdata  = s1_data;
  end

  // A result held through clken=0 is shown once clken returns.
  assign readdatavalid = out_valid & clken & ~reset;
  assign waitrequest   = reset | (state != ST_READY) | ~clken;

endmodule

// File: tb/tb_mysopc_onchip_ram_pipelined.sv
// Bench for mysopc_onchip_ram_pipelined. Two instances share the bus:
// port 0 is DEPTH=16, latency 1, clear on reset; port 1 is DEPTH=12000,
// latency 2, no clear. Reads push expected data and due cycle to a queue.
module tb_mysopc_onchip_ram_pipelined;

  logic        clk = 1'b0;
  logic        reset, clken, a_cs, b_cs, read, write;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rdv, b_rdv, a_wait, b_wait, a_oob, b_oob;

  int checks = 0;
  int errors = 0;
  int ccount = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit          sel;
    bit          rd;
    bit          wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          oob;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vec[$];

  always #5 clk = ~clk;

  mysopc_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(16),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) u_a (
    .clk(clk), .reset(reset), .clken(clken), .chipselect(a_cs),
    .read(read), .write(write), .address(address), .byteenable(byteenable),
    .writedata(writedata), .readdata(a_rdata), .readdatavalid(a_rdv),
    .waitrequest(a_wait), .oob_error(a_oob)
  );

  mysopc_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(14), .DEPTH(12000),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0), .INIT_FILE("")
  ) u_b (
    .clk(clk), .reset(reset), .clken(clken), .chipselect(b_cs),
    .read(read), .write(write), .address(address), .byteenable(byteenable),
    .writedata(writedata), .readdata(b_rdata), .readdatavalid(b_rdv),
    .waitrequest(b_wait), .oob_error(b_oob)
  );

  // Enabled-cycle counter used as the latency time base.
  always @(posedge clk) if (clken) ccount <= ccount + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic pop(input bit s);
    if (s) void'(qb.pop_front());
    else   void'(qa.pop_front());
  endtask

  // Scoreboard monitor for one port.
  task automatic mon(input bit s);
    logic        v;
    logic [31:0] d;
    bit          have;
    exp_t        e;
    v    = s ? b_rdv : a_rdv;
    d    = s ? b_rdata : a_rdata;
    have = s ? (qb.size() != 0) : (qa.size() != 0);
    e    = '{data: 32'h0, due: 0};
    if (have) e = s ? qb[0] : qa[0];
    if (v) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL spurious_rdv port%0d: readdatavalid=1 readdata=%h, required no pulse", s, d);
      end else begin
        pop(s);
        if (d !== e.data || ccount != e.due) begin
          errors++;
          $display("FAIL read_result port%0d: readdata=%h at cycle %0d, required %h at cycle %0d",
                   s, d, ccount, e.data, e.due);
        end
      end
    end else if (have && clken && !reset && ccount >= e.due) begin
      checks++;
      errors++;
      $display("FAIL missing_rdv port%0d: readdatavalid=0 at cycle %0d, required %h", s, ccount, e.data);
      pop(s);
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  task automatic add(input bit s, input bit rd, input bit wr, input logic [13:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rv,
                     input bit oob);
    vec.push_back('{sel: s, rd: rd, wr: wr, addr: a, be: be, wdata: wd, rdata: rv, oob: oob});
  endtask

  task automatic idle();
    a_cs = 1'b0; b_cs = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_ready(input bit s);
    int n = 0;
    while ((s ? b_wait : a_wait) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (s ? b_wait : a_wait) begin
      checks++; errors++;
      $display("FAIL wait_ready port%0d: waitrequest=1 after 50 cycles, required 0", s);
    end
  endtask

  task automatic drain();
    int n = 0;
    repeat (3) @(negedge clk);
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, required 0", qa.size() + qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      wait_ready(vec[i].sel);
      a_cs       = !vec[i].sel;
      b_cs       = vec[i].sel;
      read       = vec[i].rd;
      write      = vec[i].wr;
      address    = vec[i].addr;
      byteenable = vec[i].be;
      writedata  = vec[i].wdata;
      if (vec[i].rd && !vec[i].wr) begin
        if (vec[i].sel) qb.push_back('{data: vec[i].rdata, due: ccount + 2});
        else            qa.push_back('{data: vec[i].rdata, due: ccount + 1});
      end
      @(posedge clk); #1;
      chk($sformatf("oob_vec%0d", i), vec[i].sel ? b_oob : a_oob, 32'(vec[i].oob));
    end
    idle();
    drain();
  endtask

  initial begin
    int ca, cb, pa, pb, pc;
    bit bv;
    reset = 1'b1; clken = 1'b1; byteenable = 4'hF; writedata = '0; address = '0;
    idle();

    // Port 0: clear contents, byte lanes, write-then-read, read+write, out of range.
    for (int i = 0; i < 16; i++) add(0, 1, 0, 14'(i), 4'hF, 0, 32'h0, 0);
    add(0, 0, 1, 14'd5, 4'hF,    32'hAABBCCDD, 0, 0);
    add(0, 0, 1, 14'd5, 4'b0101, 32'h11223344, 0, 0);
    add(0, 1, 0, 14'd5, 4'hF, 0, 32'hAA22CC44, 0);
    add(0, 0, 1, 14'd3, 4'hF, 32'h00000055, 0, 0);
    add(0, 1, 0, 14'd3, 4'hF, 0, 32'h00000055, 0);
    add(0, 1, 1, 14'd7, 4'hF, 32'h00000077, 0, 0);
    add(0, 1, 0, 14'd7, 4'hF, 0, 32'h00000077, 0);
    add(0, 0, 1, 14'd16, 4'hF, 32'hDEADBEEF, 0, 1);
    add(0, 1, 0, 14'd0, 4'hF, 0, 32'h0, 1);
    add(0, 1, 0, 14'd17, 4'hF, 0, 32'h0, 1);
    add(0, 1, 0, 14'd5, 4'hF, 0, 32'hAA22CC44, 1);
    pa = vec.size();
    // Port 1: streaming latency-2 reads, out of range with alias check.
    for (int i = 0; i < 4; i++) add(1, 0, 1, 14'(i), 4'hF, 32'h10 + 32'(i), 0, 0);
    add(1, 0, 1, 14'd3808, 4'hF, 32'hCAFE0001, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 14'(i), 4'hF, 0, 32'h10 + 32'(i), 0);
    add(1, 0, 1, 14'd12000, 4'hF, 32'hDEADBEEF, 0, 1);
    add(1, 1, 0, 14'd3808, 4'hF, 0, 32'hCAFE0001, 1);
    add(1, 1, 0, 14'd12001, 4'hF, 0, 32'h0, 1);
    add(1, 1, 0, 14'd16383, 4'hF, 0, 32'h0, 1);
    add(1, 1, 0, 14'd3, 4'hF, 0, 32'h13, 1);
    pb = vec.size();
    // After the second reset: sticky flag cleared, port 0 zeroed, port 1 kept.
    add(0, 1, 0, 14'd5, 4'hF, 0, 32'h0, 0);
    add(0, 1, 0, 14'd12, 4'hF, 0, 32'h0, 0);
    add(1, 1, 0, 14'd3808, 4'hF, 0, 32'hCAFE0001, 0);
    add(1, 1, 0, 14'd0, 4'hF, 0, 32'h10, 0);
    pc = vec.size();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rdata", a_rdata, 0); chk("rst_a_rdv", a_rdv, 0);
    chk("rst_a_wait", a_wait, 1);   chk("rst_a_oob", a_oob, 0);
    chk("rst_b_rdata", b_rdata, 0); chk("rst_b_rdv", b_rdv, 0);
    chk("rst_b_wait", b_wait, 1);   chk("rst_b_oob", b_oob, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    ca = 0; cb = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_wait) ca++;
      if (b_wait) cb++;
      if (!a_wait && !b_wait) break;
    end
    chk("clear_wait_cycles", 32'(ca), 32'd16);
    chk("noclear_wait_cycles", 32'(cb), 32'd1);

    run_vectors(0, pa);
    run_vectors(pa, pb);
    chk("b_readdata_hold", b_rdata, 32'h13);

    // clken stall with one read in flight on port 0.
    @(posedge clk); #1;
    wait_ready(0);
    a_cs = 1'b1; read = 1'b1; address = 14'd5;
    qa.push_back('{data: 32'hAA22CC44, due: ccount + 1});
    @(posedge clk); #1;
    idle();
    clken = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("stall_rdv%0d", n), a_rdv, 0);
      chk($sformatf("stall_wait%0d", n), a_wait, 1);
      @(posedge clk); #1;
    end
    clken = 1'b1;
    drain();

    // Reset while port 0 clears word 7, with a port 1 read in flight.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midclear_wait", a_wait, 1);
    b_cs = 1'b1; read = 1'b1; address = 14'd3;
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    ca = 0; bv = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_rdv) bv = 1'b1;
      if (a_wait) ca++;
      else break;
    end
    chk("restart_wait_cycles", 32'(ca), 32'd16);
    chk("pending_read_dropped", 32'(bv), 32'd0);
    chk("oob_a_cleared", a_oob, 0);
    chk("oob_b_cleared", b_oob, 0);

    run_vectors(pb, pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
